riscv_main_control: RTL and testbench

- Main control FSM for the multicycle RISC-V datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives all datapath enables and mux selects, and generates the 2-bit ALUOp consumed by the ALU control decoder.
- Supports R-type, lw, sw and beq; supports memory stalls via a ready handshake; counts retired instructions.

---
 rtl/riscv_main_control.sv | 159 +++++++++++++++
 tb/tb_riscv_main_control.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_main_control.sv
// Main control FSM for the multicycle RISC-V datapath: sequences fetch, decode,
// execute, memory and writeback, drives datapath controls and counts retired instructions.
module riscv_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCSource,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_q;
  state_t state_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:           state_d = S_EXEC;
          OP_LOAD, OP_STORE:  state_d = S_MEMADR;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LOAD)       state_d = S_MEMRD;
        else if (opcode == OP_STORE) state_d = S_MEMWR;
        else                         state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are Moore-decoded; mem_ready qualifies FETCH/MEMWR and opcode flags illegal in DECODE.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 1'b0;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b10;
          if (opcode != OP_RTYPE && opcode != OP_LOAD &&
              opcode != OP_STORE && opcode != OP_BRANCH) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 1'b1;
          instr_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        retired <= '0;
    else if (instr_done && !illegal_op) retired <= retired + CNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_riscv_main_control.sv
// Directed self-checking bench for riscv_main_control: per-cycle state and control
// vectors for each instruction class, stalls, illegal opcode, async reset and counter wrap.
module tb_riscv_main_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        mem_ready;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, ALUSrcA, PCSource, illegal_op, instr_done;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite;
  logic        w_MemtoReg, w_RegWrite, w_ALUSrcA, w_PCSource, w_illegal_op, w_instr_done;
  logic [1:0]  w_ALUSrcB, w_ALUOp;
  logic [3:0]  w_state;
  logic [3:0]  w_retired;

  int checks = 0;
  int errors = 0;

  // Expected control vectors, bit order:
  // PCWrite PCWriteCond IorD MemRead | MemWrite IRWrite MemtoReg RegWrite |
  // ALUSrcA ALUSrcB[1:0] PCSource | ALUOp[1:0] illegal_op instr_done
  localparam logic [15:0] C_FETCH_RDY = 16'h9420;
  localparam logic [15:0] C_FETCH_STL = 16'h1020;
  localparam logic [15:0] C_DECODE    = 16'h0040;
  localparam logic [15:0] C_DECODE_IL = 16'h0043;
  localparam logic [15:0] C_MEMADR    = 16'h00C0;
  localparam logic [15:0] C_MEMRD     = 16'h3000;
  localparam logic [15:0] C_MEMWB     = 16'h0301;
  localparam logic [15:0] C_MEMWR_STL = 16'h2800;
  localparam logic [15:0] C_MEMWR_RDY = 16'h2801;
  localparam logic [15:0] C_EXEC      = 16'h0088;
  localparam logic [15:0] C_ALUWB     = 16'h0101;
  localparam logic [15:0] C_BRANCH    = 16'h4095;

  riscv_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .state(state), .illegal_op(illegal_op), .instr_done(instr_done), .retired(retired)
  );

  riscv_main_control #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD), .MemRead(w_MemRead),
    .MemWrite(w_MemWrite), .IRWrite(w_IRWrite), .MemtoReg(w_MemtoReg), .RegWrite(w_RegWrite),
    .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .PCSource(w_PCSource), .ALUOp(w_ALUOp),
    .state(w_state), .illegal_op(w_illegal_op), .instr_done(w_instr_done), .retired(w_retired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctrl_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
            ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op, instr_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Checks the current cycle (inputs applied), then advances to 1 time unit after the next edge.
  task automatic cycle(input string tag, input logic rdy, input logic [3:0] exp_state,
                       input logic [15:0] exp_ctrl);
    mem_ready = rdy;
    #1;
    check({tag, " state"}, 32'(state), 32'(exp_state));
    check({tag, " ctrl"}, 32'(ctrl_vec()), 32'(exp_ctrl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset ctrl", 32'(ctrl_vec()), 32'd0);
    check("reset retired", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // R-type: 0,1,6,7,0
    opcode = 7'b0110011;
    cycle("r fetch",  1'b1, 4'd0, C_FETCH_RDY);
    cycle("r decode", 1'b0, 4'd1, C_DECODE);
    cycle("r exec",   1'b0, 4'd6, C_EXEC);
    check("r retired before", retired, 32'd0);
    cycle("r aluwb",  1'b0, 4'd7, C_ALUWB);
    check("r retired after", retired, 32'd1);

    // lw with two MEMRD stall cycles: 0,1,2,3,3,3,4,0; early mem_ready in DECODE/MEMADR ignored
    opcode = 7'b0000011;
    cycle("lw fetch",  1'b1, 4'd0, C_FETCH_RDY);
    cycle("lw decode", 1'b1, 4'd1, C_DECODE);
    cycle("lw memadr", 1'b1, 4'd2, C_MEMADR);
    cycle("lw memrd0", 1'b0, 4'd3, C_MEMRD);
    cycle("lw memrd1", 1'b0, 4'd3, C_MEMRD);
    cycle("lw memrd2", 1'b1, 4'd3, C_MEMRD);
    cycle("lw memwb",  1'b0, 4'd4, C_MEMWB);
    check("lw retired", retired, 32'd2);

    // sw with one FETCH stall: 0,0,1,2,5,0
    opcode = 7'b0100011;
    cycle("sw fetch0", 1'b0, 4'd0, C_FETCH_STL);
    cycle("sw fetch1", 1'b1, 4'd0, C_FETCH_RDY);
    cycle("sw decode", 1'b0, 4'd1, C_DECODE);
    cycle("sw memadr", 1'b0, 4'd2, C_MEMADR);
    cycle("sw memwr",  1'b1, 4'd5, C_MEMWR_RDY);
    check("sw retired", retired, 32'd3);

    // beq: 0,1,8,0
    opcode = 7'b1100011;
    cycle("beq fetch",  1'b1, 4'd0, C_FETCH_RDY);
    cycle("beq decode", 1'b0, 4'd1, C_DECODE);
    cycle("beq branch", 1'b0, 4'd8, C_BRANCH);
    check("beq retired", retired, 32'd4);

    // Illegal opcode: 0,1,0 with no retire
    opcode = 7'b1111111;
    cycle("ill fetch",  1'b1, 4'd0, C_FETCH_RDY);
    cycle("ill decode", 1'b0, 4'd1, C_DECODE_IL);
    mem_ready = 1'b0;
    #1;
    check("ill back to fetch", 32'(state), 32'd0);
    check("ill retired", retired, 32'd4);
    #1;

    // sw stalled in MEMWR, then asynchronous reset mid-clock
    opcode = 7'b0100011;
    cycle("rst fetch",  1'b1, 4'd0, C_FETCH_RDY);
    cycle("rst decode", 1'b0, 4'd1, C_DECODE);
    cycle("rst memadr", 1'b0, 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    #1;
    check("rst memwr stall state", 32'(state), 32'd5);
    check("rst memwr stall ctrl", 32'(ctrl_vec()), 32'(C_MEMWR_STL));
    #1;
    reset = 1'b0;
    #1;
    check("rst async state", 32'(state), 32'd0);
    check("rst async MemWrite", 32'(MemWrite), 32'd0);
    check("rst async ctrl", 32'(ctrl_vec()), 32'd0);
    check("rst async retired", retired, 32'd0);
    @(posedge clk);
    #1;
    check("rst held state", 32'(state), 32'd0);
    check("rst held retired", retired, 32'd0);
    reset = 1'b1;
    cycle("rst rel fetch",  1'b1, 4'd0, C_FETCH_RDY);
    cycle("rst rel decode", 1'b0, 4'd1, C_DECODE);
    cycle("rst rel memadr", 1'b0, 4'd2, C_MEMADR);
    cycle("rst rel memwr",  1'b1, 4'd5, C_MEMWR_RDY);
    check("rst rel retired", retired, 32'd1);

    // Reset again, then 16 R-types: the 4-bit counter wraps 15 -> 0
    reset = 1'b0;
    #1;
    reset = 1'b1;
    opcode = 7'b0110011;
    for (int i = 0; i < 16; i++) begin
      cycle("wrap fetch",  1'b1, 4'd0, C_FETCH_RDY);
      cycle("wrap decode", 1'b0, 4'd1, C_DECODE);
      cycle("wrap exec",   1'b0, 4'd6, C_EXEC);
      cycle("wrap aluwb",  1'b0, 4'd7, C_ALUWB);
      check($sformatf("wrap retired32 %0d", i), retired, 32'(i + 1));
      check($sformatf("wrap retired4 %0d", i), 32'(w_retired), 32'((i + 1) % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
